// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master command path.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [SEL_W-1:0]  psel;
        logic              pwrite;
        logic [APB_AW-1:0] paddr;
        logic [APB_DW-1:0] pwdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_slot.sv
// One-entry pending command register. When empty, the incoming command is
// presented straight on cmd_o so an idle master can start it without delay.
module apb_cmd_slot
    import apb_pkg::*;
(
    input  logic     rd_clk,
    input  logic     rst,
    input  logic     load_i,
    input  logic     take_i,
    input  apb_cmd_t cmd_i,
    output logic     full_o,
    output logic     overflow_o,
    output apb_cmd_t cmd_o
);

    logic     full_q, full_d;
    logic     ovf_q, ovf_d;
    apb_cmd_t data_q, data_d;

    // Next-state for occupancy, stored command and the sticky drop flag
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (full_q) begin
            if (take_i) begin
                // slot drains this cycle, so a simultaneous command refills it
                full_d = load_i;
                if (load_i) begin
                    data_d = cmd_i;
                end
            end else if (load_i) begin
                ovf_d = 1'b1;
            end
        end else if (load_i && !take_i) begin
            // an empty slot that is taken in the same cycle is a pass-through
            full_d = 1'b1;
            data_d = cmd_i;
        end
    end

    // Slot registers
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            ovf_q  <= ovf_d;
            data_q <= data_d;
        end
    end

    assign full_o     = full_q;
    assign overflow_o = ovf_q;
    assign cmd_o      = full_q ? data_q : cmd_i;

endmodule

// File: rtl/apb_master_if.sv
// APB3 master: executes one assembled command per transfer, with a single
// pending slot, one-hot slave select, slave error and timeout reporting.
module apb_master_if
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [SEL_W-1:0]      i_psel,
    input  logic                  i_pwrite,
    input  logic [APB_AW-1:0]     i_paddr,
    input  logic [APB_DW-1:0]     i_pwdata,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic                  o_done,
    output logic [APB_DW-1:0]     o_rdata,
    output logic                  o_err,
    output logic                  o_timeout,
    output logic [NUM_SLAVES-1:0] m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [APB_AW-1:0]     m_paddr,
    output logic [APB_DW-1:0]     m_pwdata,
    input  logic                  slv_pready,
    input  logic [APB_DW-1:0]     m_prdata,
    input  logic                  m_pslverr
);

    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TMAX);

    apb_cmd_t   in_cmd, slot_cmd;
    logic       slot_full, take, load_bus, idx_ok, timeout_hit;
    logic [NUM_SLAVES-1:0] sel_dec;

    apb_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_AW-1:0]     paddr_q, paddr_d;
    logic [APB_DW-1:0]     pwdata_q, pwdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic [APB_DW-1:0]     rdata_q, rdata_d;

    assign in_cmd = '{psel: i_psel, pwrite: i_pwrite, paddr: i_paddr, pwdata: i_pwdata};

    apb_cmd_slot u_slot (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .load_i     (i_valid),
        .take_i     (take),
        .cmd_i      (in_cmd),
        .full_o     (slot_full),
        .overflow_o (o_overflow),
        .cmd_o      (slot_cmd)
    );

    assign idx_ok = (32'(slot_cmd.psel) < 32'(NUM_SLAVES));

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
        assign sel_dec[gi] = (slot_cmd.psel == SEL_W'(gi));
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !slv_pready && (cnt_q == CNT_LAST);

    // Transfer sequencing, completion capture and command hand-off
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        take      = 1'b0;
        load_bus  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_full || i_valid) begin
                    take = 1'b1;
                    if (idx_ok) begin
                        load_bus = 1'b1;
                    end else begin
                        // unreachable slave: report immediately, bus untouched
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (slv_pready) begin
                    done_d = 1'b1;
                    err_d  = m_pslverr;
                    if (!pwrite_q) begin
                        rdata_d = m_prdata;
                    end
                end else if (timeout_hit) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    tmo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (slv_pready || timeout_hit) begin
                    // only a held command chains directly; a bad index goes
                    // through IDLE so its own done pulse does not collide
                    if (slot_full && idx_ok) begin
                        take     = 1'b1;
                        load_bus = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        psel_d    = '0;
                        penable_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
        if (load_bus) begin
            state_d   = ST_SETUP;
            cnt_d     = '0;
            psel_d    = sel_dec;
            penable_d = 1'b0;
            pwrite_d  = slot_cmd.pwrite;
            paddr_d   = slot_cmd.paddr;
            pwdata_d  = slot_cmd.pwdata;
        end
    end

    // State, bus and status registers
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_busy    = (state_q != ST_IDLE) | slot_full;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_timeout = tmo_q;
    assign o_rdata   = rdata_q;
    assign m_psel    = psel_q;
    assign m_penable = penable_q;
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pwdata  = pwdata_q;

endmodule
